// File: rtl/ps2_keyboard_receiver.sv
// ps2_keyboard_receiver: PS/2 keyboard frame receiver with sync, deglitch, parity/framing check.
// Define PS2_BREAK_FILTER_EN to absorb the 0xF0 break prefix and report it on KeyReleased.
module ps2_keyboard_receiver #(
    parameter int FILTER_DEPTH   = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2Clock,
    input  logic       PS2Data,
    output logic [7:0] KeyCode,
    output logic       KeyValid,
    output logic       KeyReleased,
    output logic       ParityError,
    output logic       FrameError
);
    localparam int FW = $clog2(FILTER_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          filt_q, filt_d, filt_prev_q;
    logic          bit_evt, bit_val;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d, code_q, code_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
`ifdef PS2_BREAK_FILTER_EN
    logic          brk_q, brk_d, rel_q, rel_d;
`endif
    // Filtered clock flips only after FILTER_DEPTH consecutive disagreeing samples
    always_comb begin
        flt_cnt_d = '0;
        filt_d    = filt_q;
        if (clk_sync_q[1] != filt_q) begin
            if (flt_cnt_q == FW'(FILTER_DEPTH - 1)) filt_d = clk_sync_q[1];
            else flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end
    assign bit_evt = filt_prev_q & ~filt_q;
    assign bit_val = dat_sync_q[1];
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = '0;
        code_d    = code_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        brk_d     = brk_q;
        rel_d     = 1'b0;
`endif
        if (state_q != IDLE) tmo_d = bit_evt ? '0 : tmo_q + 1'b1;
        if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
            state_d = IDLE;
`ifdef PS2_BREAK_FILTER_EN
            brk_d   = 1'b0;
`endif
        end else if (bit_evt) begin
            case (state_q)
                IDLE: begin
                    state_d   = bit_val ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = bit_val;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!bit_val) ferr_d = 1'b1;
                    else if (!(^shift_q ^ par_q)) perr_d = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                    else if (shift_q == 8'hF0) brk_d = 1'b1;
                    else begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                        rel_d   = brk_q;
                        brk_d   = 1'b0;
                    end
`else
                    else begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                    end
`endif
                end
            endcase
        end
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            flt_cnt_q   <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2Clock};
            dat_sync_q  <= {dat_sync_q[0], PS2Data};
            flt_cnt_q   <= flt_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end
`ifdef PS2_BREAK_FILTER_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            brk_q <= 1'b0;
            rel_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
            rel_q <= rel_d;
        end
    end
    assign KeyReleased = rel_q;
`else
    assign KeyReleased = 1'b0;
`endif
    assign KeyCode     = code_q;
    assign KeyValid    = valid_q;
    assign ParityError = perr_q;
    assign FrameError  = ferr_q;
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb_ps2_keyboard_receiver: directed bench for ps2_keyboard_receiver (honours PS2_BREAK_FILTER_EN).
module tb_ps2_keyboard_receiver;
    localparam int HP  = 20;
    localparam int TMO = 1000;
    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       PS2Clock = 1'b1;
    logic       PS2Data = 1'b1;
    logic [7:0] KeyCode;
    logic       KeyValid, KeyReleased, ParityError, FrameError;
    int         vectors = 0;
    int         miscompares = 0;
    int         n_valid = 0, n_perr = 0, n_ferr = 0, n_overlap = 0, n_rel_stray = 0;
    logic [7:0] last_code = 8'h00, prev_code = 8'h00;
    logic       last_rel = 1'b0;

    ps2_keyboard_receiver #(.FILTER_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock(Clock), .Reset(Reset), .PS2Clock(PS2Clock), .PS2Data(PS2Data),
        .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyReleased(KeyReleased),
        .ParityError(ParityError), .FrameError(FrameError)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (KeyValid) begin
            n_valid   <= n_valid + 1;
            prev_code <= last_code;
            last_code <= KeyCode;
            last_rel  <= KeyReleased;
        end
        if (ParityError) n_perr <= n_perr + 1;
        if (FrameError) n_ferr <= n_ferr + 1;
        if (int'(KeyValid) + int'(ParityError) + int'(FrameError) > 1) n_overlap <= n_overlap + 1;
        if (KeyReleased && !KeyValid) n_rel_stray <= n_rel_stray + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            PS2Data = bits[i];
            wait_cycles(HP);
            PS2Clock = 1'b0;
            wait_cycles(HP);
            PS2Clock = 1'b1;
        end
        wait_cycles(HP);
        PS2Data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
        wait_cycles(40);
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        wait_cycles(5);
        vectors++;
        if ({KeyCode, KeyValid, KeyReleased, ParityError, FrameError} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 000", {KeyCode, KeyValid, KeyReleased, ParityError, FrameError});
        end
        Reset = 1'b1;
        wait_cycles(10);
        vectors++;
        if (KeyCode !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_keycode_after_release: got %h expected 00", KeyCode);
        end
    endtask

    task automatic test_make;
        int v0;
        v0 = n_valid;
        send_frame(8'h1C, 1'b0, 1'b0);
        vectors++;
        if (n_valid - v0 !== 1) begin
            miscompares++;
            $display("FAIL make_valid_count: got %0d expected 1", n_valid - v0);
        end
        vectors++;
        if (last_code !== 8'h1C || last_rel !== 1'b0) begin
            miscompares++;
            $display("FAIL make_code: got %h rel %b expected 1c rel 0", last_code, last_rel);
        end
        wait_cycles(1000);
        vectors++;
        if (KeyCode !== 8'h1C) begin
            miscompares++;
            $display("FAIL make_hold: got %h expected 1c", KeyCode);
        end
    endtask

    task automatic test_break;
        int v0;
        v0 = n_valid;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
        vectors++;
        if (n_valid - v0 !== 1 || last_code !== 8'h1C || last_rel !== 1'b1) begin
            miscompares++;
            $display("FAIL break_release: got cnt %0d code %h rel %b expected cnt 1 code 1c rel 1", n_valid - v0, last_code, last_rel);
        end
        v0 = n_valid;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        vectors++;
        if (n_valid - v0 !== 1 || last_code !== 8'h24 || last_rel !== 1'b1) begin
            miscompares++;
            $display("FAIL double_break: got cnt %0d code %h rel %b expected cnt 1 code 24 rel 1", n_valid - v0, last_code, last_rel);
        end
`else
        vectors++;
        if (n_valid - v0 !== 2 || prev_code !== 8'hF0 || last_code !== 8'h1C || last_rel !== 1'b0) begin
            miscompares++;
            $display("FAIL break_passthru: got cnt %0d codes %h,%h rel %b expected cnt 2 codes f0,1c rel 0", n_valid - v0, prev_code, last_code, last_rel);
        end
`endif
    endtask

    task automatic test_errors;
        int v0, p0, f0;
        logic [7:0] held;
        held = KeyCode;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b1, 1'b0);
        vectors++;
        if (n_perr - p0 !== 1 || n_valid - v0 !== 0 || n_ferr - f0 !== 0 || KeyCode !== held) begin
            miscompares++;
            $display("FAIL parity_error: got perr %0d valid %0d ferr %0d code %h expected 1 0 0 %h", n_perr - p0, n_valid - v0, n_ferr - f0, KeyCode, held);
        end
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h32, 1'b0, 1'b1);
        vectors++;
        if (n_ferr - f0 !== 1 || n_valid - v0 !== 0 || n_perr - p0 !== 0 || KeyCode !== held) begin
            miscompares++;
            $display("FAIL frame_error: got ferr %0d valid %0d perr %0d code %h expected 1 0 0 %h", n_ferr - f0, n_valid - v0, n_perr - p0, KeyCode, held);
        end
        v0 = n_valid;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        send_frame(8'h1B, 1'b0, 1'b0);
        vectors++;
`ifdef PS2_BREAK_FILTER_EN
        if (n_valid - v0 !== 1 || last_code !== 8'h1B || last_rel !== 1'b1) begin
            miscompares++;
            $display("FAIL error_keeps_break: got cnt %0d code %h rel %b expected cnt 1 code 1b rel 1", n_valid - v0, last_code, last_rel);
        end
`else
        if (n_valid - v0 !== 2 || last_code !== 8'h1B || last_rel !== 1'b0) begin
            miscompares++;
            $display("FAIL error_then_code: got cnt %0d code %h rel %b expected cnt 2 code 1b rel 0", n_valid - v0, last_code, last_rel);
        end
`endif
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = n_valid; e0 = n_perr + n_ferr;
        PS2Data = 1'b0;
        PS2Clock = 1'b0;
        wait_cycles(3);
        PS2Clock = 1'b1;
        wait_cycles(20);
        PS2Data = 1'b1;
        wait_cycles(20);
        send_frame(8'h23, 1'b0, 1'b0);
        vectors++;
        if (n_valid - v0 !== 1 || KeyCode !== 8'h23 || n_perr + n_ferr - e0 !== 0) begin
            miscompares++;
            $display("FAIL glitch: got cnt %0d code %h errs %0d expected cnt 1 code 23 errs 0", n_valid - v0, KeyCode, n_perr + n_ferr - e0);
        end
    endtask

    task automatic test_timeout;
        int v0, e0;
        send_frame(8'hF0, 1'b0, 1'b0);
        v0 = n_valid; e0 = n_perr + n_ferr;
        send_bits({2'b11, 8'h5A, 1'b0}, 5);
        wait_cycles(TMO + 10);
        vectors++;
        if (n_valid - v0 !== 0 || n_perr + n_ferr - e0 !== 0) begin
            miscompares++;
            $display("FAIL timeout_silent: got valid %0d errs %0d expected 0 0", n_valid - v0, n_perr + n_ferr - e0);
        end
        send_frame(8'h2B, 1'b0, 1'b0);
        vectors++;
        if (n_valid - v0 !== 1 || KeyCode !== 8'h2B || last_rel !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_recover: got cnt %0d code %h rel %b expected cnt 1 code 2b rel 0", n_valid - v0, KeyCode, last_rel);
        end
    endtask

    task automatic test_reset_midframe;
        int v0;
        send_bits({2'b11, 8'hFF, 1'b0}, 6);
        Reset = 1'b0;
        #1;
        vectors++;
        if ({KeyCode, KeyValid, KeyReleased, ParityError, FrameError} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_midframe: got %h expected 000", {KeyCode, KeyValid, KeyReleased, ParityError, FrameError});
        end
        wait_cycles(5);
        Reset = 1'b1;
        wait_cycles(20);
        v0 = n_valid;
        send_frame(8'h4D, 1'b0, 1'b0);
        vectors++;
        if (n_valid - v0 !== 1 || KeyCode !== 8'h4D || last_rel !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_frame: got cnt %0d code %h rel %b expected cnt 1 code 4d rel 0", n_valid - v0, KeyCode, last_rel);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = n_valid;
        send_bits({1'b1, ~^8'h15, 8'h15, 1'b0}, 11);
        send_frame(8'h2D, 1'b0, 1'b0);
        vectors++;
        if (n_valid - v0 !== 2 || prev_code !== 8'h15 || last_code !== 8'h2D) begin
            miscompares++;
            $display("FAIL back_to_back: got cnt %0d codes %h,%h expected cnt 2 codes 15,2d", n_valid - v0, prev_code, last_code);
        end
        vectors++;
        if (n_overlap !== 0 || n_rel_stray !== 0) begin
            miscompares++;
            $display("FAIL strobe_exclusive: got overlap %0d stray_rel %0d expected 0 0", n_overlap, n_rel_stray);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_errors();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_receiver.md
# ps2_keyboard_receiver

Receives PS/2 keyboard frames on the raw `PS2Clock`/`PS2Data` lines and produces the 8-bit scan code consumed by the key decoder and seven-segment display path. It is the transmitting end of the `KeyCode` interface. The block:

- synchronizes and deglitches the open-collector PS/2 lines,
- deserializes 11-bit frames and checks parity and framing,
- presents each accepted code with a one-cycle valid strobe and a release flag.

## Interface

Parameters:
- `FILTER_DEPTH`, default 4: consecutive identical synchronized samples required before the filtered PS/2 clock changes state.
- `TIMEOUT_CYCLES`, default 20000: `Clock` cycles without a filtered PS/2 falling edge before a partial frame is abandoned (200 µs at 100 MHz).

Ports (name, direction, width, meaning):
- `Clock`  in  1  system clock; all state is clocked on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `PS2Clock`  in  1  raw PS/2 clock from the keyboard; asynchronous.
- `PS2Data`  in  1  raw PS/2 data from the keyboard; asynchronous.
- `KeyCode`  out  8  last accepted scan code; held between frames.
- `KeyValid`  out  1  one-cycle strobe; `KeyCode` is new this cycle.
- `KeyReleased`  out  1  valid with `KeyValid`; 1 when the code followed a 0xF0 break prefix.
- `ParityError`  out  1  one-cycle strobe; frame dropped because odd parity failed.
- `FrameError`  out  1  one-cycle strobe; frame dropped because the stop bit was 0.

## Operation

Input conditioning:
- `PS2Clock` and `PS2Data` each pass through a 2-flop synchronizer.
- Filtered clock (reset value 1) takes the synchronized value once that value has been seen for `FILTER_DEPTH` consecutive cycles and differs from the current filtered value.
- A falling edge of the filtered clock is a bit event. At each bit event the synchronized `PS2Data` is sampled.

State machine (reset state IDLE):
- **IDLE**: on a bit event, sampled 0 moves to DATA with bit counter cleared; sampled 1 is ignored.
- **DATA**: shift the 8 bits in LSB first; after the 8th bit event, go to PARITY.
- **PARITY**: capture the parity bit, go to STOP.
- **STOP**: evaluate the frame, then return to IDLE.
  - Stop bit 0: pulse `FrameError`.
  - Else, XOR of the 8 data bits and the parity bit equal to 0: pulse `ParityError`.
  - Else the byte is accepted.
- **Timeout**: in any non-IDLE state, a cycle counter clears on each bit event. When it reaches `TIMEOUT_CYCLES`, return to IDLE, discard the partial frame, clear the break-pending flag, and strobe nothing.

Accepted-byte handling (break filter enabled, see Configuration):
- Byte 0xF0: set break-pending; no `KeyValid`.
- Any other byte: load `KeyCode`, pulse `KeyValid`, drive `KeyReleased` = break-pending, then clear break-pending.
- Two consecutive 0xF0 bytes leave break-pending set.
- An error frame does not change break-pending.

Reset values: `KeyCode` = 0x00; `KeyValid`, `KeyReleased`, `ParityError`, `FrameError` = 0; break-pending = 0; state IDLE; filtered clock = 1. Asserting `Reset` mid-frame discards the frame immediately. After `Reset` deasserts, the block waits for a fresh start bit.

## Timing

- Raw `PS2Clock` falling edge to bit sample: `FILTER_DEPTH`+3 `Clock` cycles (2 sync, `FILTER_DEPTH` filter, 1 edge detect).
- `KeyValid`, `ParityError` and `FrameError` are registered and assert in the cycle after the stop-bit sample. Each is high for exactly one cycle.
- `KeyCode` and `KeyReleased` change in the same cycle that `KeyValid` rises. `KeyCode` then holds until the next `KeyValid`. `KeyReleased` returns to 0 the following cycle.
- At most one of `KeyValid`, `ParityError`, `FrameError` is high in any cycle.
- A PS/2 clock glitch shorter than `FILTER_DEPTH` cycles produces no bit event.

## Configuration

- `PS2_BREAK_FILTER_EN` defined: 0xF0 prefix absorbed and reported through `KeyReleased`, as described above.
- `PS2_BREAK_FILTER_EN` undefined: every accepted byte, including 0xF0, is loaded into `KeyCode` with a `KeyValid` pulse. `KeyReleased` is tied to 0 and no break-pending state exists.

## Test plan

- Frame for 0x1C (a make code), odd parity correct -> one `KeyValid` pulse, `KeyCode`=0x1C, `KeyReleased`=0; `KeyCode` still 0x1C 1000 cycles later.
- Frames 0xF0 then 0x1C with filter enabled -> exactly one `KeyValid`, `KeyCode`=0x1C, `KeyReleased`=1. With macro undefined -> two `KeyValid` pulses: 0xF0, then 0x1C.
- Frame 0x1C with parity bit inverted -> one `ParityError` pulse, no `KeyValid`, `KeyCode` unchanged. Frame 0x32 with stop bit 0 -> one `FrameError` pulse only.
- 3-cycle low glitch on `PS2Clock` while idle, then a valid 0x23 frame -> glitch ignored, `KeyCode`=0x23.
- Start bit plus 4 data bits, then silence for `TIMEOUT_CYCLES`+10 cycles, then a valid 0x2B frame -> no strobes from the partial frame, then `KeyCode`=0x2B. Separately, `Reset` asserted after bit 5 of a frame -> all outputs 0 immediately, and the next full frame decodes correctly.
